// File: rtl/cal_pkg.sv
// Shared encodings for the sequential calculator.
//   op_e    : operation select carried on the 2-bit op port
//   state_e : control FSM states
package cal_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Width of an iteration counter able to hold 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cal_iter_step.sv
// One combinational iteration of the multi-cycle datapath.
//   op         : OP_MUL selects shift-add, anything else restoring divide
//   m          : multiplicand (mul) or divisor (div)
//   hi, lo     : working pair; mul {partial product, multiplier},
//                div {partial remainder, dividend/quotient}
//   hi_n, lo_n : working pair after this iteration
module cal_iter_step
  import cal_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // shift-add: conditionally add, then shift {carry,hi,lo} right by one
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    // restoring divide: bring next dividend bit into the partial remainder
    sh   = {hi, lo[WIDTH-1]};
    // when sh >= m the difference is < m, so WIDTH bits are enough
    diff = sh[WIDTH-1:0] - m;
    if (op == OP_MUL) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else if (sh >= {1'b0, m}) begin
      hi_n = diff;
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = sh[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/cal_alu_seq.sv
// Sequential unsigned ALU: single-cycle add/sub, WIDTH-iteration mul/div.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, sampled only while idle (busy=0)
//   op, a, b     : operation select and unsigned operands
//   busy         : operation in progress (CALC or DONE)
//   done         : one-cycle pulse, result/flag valid
//   result, flag : registered result, carry/borrow/div-by-zero flag
module cal_alu_seq
  import cal_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] m_q, hi_q, lo_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [CW-1:0]    cnt;

  logic [2*WIDTH-1:0] add_res, sub_res, dz_res;

  cal_iter_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .m    (m_q),
    .hi   (hi_q),
    .lo   (lo_q),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  // single-cycle results, zero-extended to the full result width
  always_comb begin
    add_res          = '0;
    add_res[WIDTH:0] = {1'b0, a} + {1'b0, b};
    sub_res          = '0;
    sub_res[WIDTH-1:0] = a - b;
    // divide by zero: remainder = a, quotient = all ones
    dz_res           = {a, {WIDTH{1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            op_q <= op_e'(op);
            cnt  <= '0;
            case (op_e'(op))
              OP_ADD: begin
                result <= add_res;
                flag   <= add_res[WIDTH];
                done   <= 1'b1;
                state  <= DONE;
              end
              OP_SUB: begin
                result <= sub_res;
                flag   <= (a < b);
                done   <= 1'b1;
                state  <= DONE;
              end
              OP_MUL: begin
                m_q   <= a;
                hi_q  <= '0;
                lo_q  <= b;
                state <= CALC;
              end
              default: begin // OP_DIV
                if (b == '0) begin
                  result <= dz_res;
                  flag   <= 1'b1;
                  done   <= 1'b1;
                  state  <= DONE;
                end else begin
                  m_q   <= b;
                  hi_q  <= '0;
                  lo_q  <= a;
                  state <= CALC;
                end
              end
            endcase
          end
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + CW'(1);
          // result is only written from the final iteration so partial
          // products/remainders never reach the output
          if (cnt == LAST) begin
            result <= {hi_n, lo_n};
            flag   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cal_alu_seq.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=8 instance, each tracked every
// cycle by a transaction-level reference model; directed literal cases pin
// the model, then random traffic (including resets) runs on both.
module tb_cal_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_i [2];
  logic [1:0] op_i    [2];
  logic [7:0] a_i     [2];
  logic [7:0] b_i     [2];

  logic        busy4, done4, flag4;
  logic [7:0]  res4;
  logic        busy8, done8, flag8;
  logic [15:0] res8;

  cal_alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_i[0]), .op(op_i[0]),
    .a(a_i[0][3:0]), .b(b_i[0][3:0]),
    .busy(busy4), .done(done4), .result(res4), .flag(flag4)
  );

  cal_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_i[1]), .op(op_i[1]),
    .a(a_i[1]), .b(b_i[1]),
    .busy(busy8), .done(done8), .result(res8), .flag(flag8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void refcalc(input int w, input int o, input longint x, input longint y,
                                  output longint r, output bit f, output int lat);
    longint mask;
    mask = (longint'(1) << w) - 1;
    f = 1'b0;
    case (o)
      0: begin r = x + y; f = ((r >> w) & 1) != 0; end
      1: begin r = (x - y) & mask; f = (x < y); end
      2: r = x * y;
      default: begin
        if (y == 0) begin r = (x << w) | mask; f = 1'b1; end
        else r = ((x % y) << w) | (x / y);
      end
    endcase
    lat = (o == 2 || (o == 3 && y != 0)) ? w + 1 : 1;
  endfunction

  bit     m_busy [2];
  bit     m_done [2];
  longint m_res  [2];
  bit     m_flag [2];
  int     m_k    [2];
  int     m_lat  [2];
  longint p_res  [2];
  bit     p_flag [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_done[u] = 0; m_res[u] = 0; m_flag[u] = 0; m_k[u] = 0; m_lat[u] = 1;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int u = 0; u < 2; u++) begin
        int     w;
        longint mask;
        w = (u == 0) ? 4 : 8;
        mask = (longint'(1) << w) - 1;
        if (rst) begin
          m_busy[u] = 0; m_done[u] = 0; m_res[u] = 0; m_flag[u] = 0;
        end else if (m_busy[u]) begin
          if (m_done[u]) begin
            m_busy[u] = 0; m_done[u] = 0;
          end else begin
            m_k[u]++;
            if (m_k[u] == m_lat[u]) begin
              m_done[u] = 1; m_res[u] = p_res[u]; m_flag[u] = p_flag[u];
            end
          end
        end else if (start_i[u]) begin
          refcalc(w, int'(op_i[u]), longint'(a_i[u]) & mask, longint'(b_i[u]) & mask,
                  p_res[u], p_flag[u], m_lat[u]);
          m_busy[u] = 1; m_k[u] = 1;
          if (m_lat[u] == 1) begin
            m_done[u] = 1; m_res[u] = p_res[u]; m_flag[u] = p_flag[u];
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("w4 busy",   64'(busy4), 64'(m_busy[0]));
    chk("w4 done",   64'(done4), 64'(m_done[0]));
    chk("w4 result", 64'(res4),  64'(m_res[0]));
    chk("w4 flag",   64'(flag4), 64'(m_flag[0]));
    chk("w8 busy",   64'(busy8), 64'(m_busy[1]));
    chk("w8 done",   64'(done8), 64'(m_done[1]));
    chk("w8 result", 64'(res8),  64'(m_res[1]));
    chk("w8 flag",   64'(flag8), 64'(m_flag[1]));
  end

  // ---------------- directed helper (WIDTH=4 instance) ----------------
  task automatic run_op(input string nm, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input bit pulse, input int exp_lat,
                        input logic [7:0] exp_res, input bit exp_flag);
    int n, bn, guard;
    bit seen;
    logic [7:0] r;
    logic f;
    guard = 0;
    @(negedge clk);
    while (busy4 && guard < 20) begin @(negedge clk); guard++; end
    #2;
    start_i[0] = 1'b1; op_i[0] = o; a_i[0] = x; b_i[0] = y;
    n = 0; bn = 0; seen = 0; r = '0; f = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy4) bn++;
      if (done4) begin seen = 1; r = res4; f = flag4; end
      #2;
      if (n == 1) start_i[0] = 1'b0;
      if (pulse && n == 2) begin start_i[0] = 1'b1; op_i[0] = 2'b00; a_i[0] = 8'd1; b_i[0] = 8'd1; end
      if (pulse && n == 3) start_i[0] = 1'b0;
    end
    start_i[0] = 1'b0;
    chk({nm, " done seen"}, 64'(seen), 64'd1);
    chk({nm, " latency"}, 64'(n), 64'(exp_lat));
    chk({nm, " busy cycles"}, 64'(bn), 64'(exp_lat));
    chk({nm, " result"}, 64'(r), 64'(exp_res));
    chk({nm, " flag"}, 64'(f), 64'(exp_flag));
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [7:0] rnd_opnd(input int w);
    logic [7:0] mask;
    mask = 8'((16'd1 << w) - 16'd1);
    case ($urandom % 4)
      0: return 8'd0;
      1: return mask;
      default: return 8'($urandom) & mask;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_i[u] = 1'b0; op_i[u] = 2'b00; a_i[u] = 8'd0; b_i[u] = 8'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset busy",   64'(busy4), 64'd0);
    chk("reset done",   64'(done4), 64'd0);
    chk("reset result", 64'(res4),  64'd0);
    chk("reset flag",   64'(flag4), 64'd0);
    #2 rst = 1'b0;

    run_op("add 9+8",   2'b00, 8'd9,  8'd8, 1'b0, 1, 8'h11, 1'b1);
    run_op("sub 3-5",   2'b01, 8'd3,  8'd5, 1'b0, 1, 8'h0E, 1'b1);
    run_op("mul 15*15", 2'b10, 8'd15, 8'd15, 1'b1, 5, 8'hE1, 1'b0);
    run_op("div 13/4",  2'b11, 8'd13, 8'd4, 1'b0, 5, 8'h13, 1'b0);
    run_op("div 7/0",   2'b11, 8'd7,  8'd0, 1'b0, 1, 8'h7F, 1'b1);
    run_op("add 15+15", 2'b00, 8'd15, 8'd15, 1'b0, 1, 8'h1E, 1'b1);
    run_op("sub 0-15",  2'b01, 8'd0,  8'd15, 1'b0, 1, 8'h01, 1'b1);
    run_op("div 15/1",  2'b11, 8'd15, 8'd1, 1'b0, 5, 8'h0F, 1'b0);

    // reset abort on the second CALC cycle of a multiply
    @(negedge clk);
    #2;
    start_i[0] = 1'b1; op_i[0] = 2'b10; a_i[0] = 8'd15; b_i[0] = 8'd15;
    @(negedge clk);
    #2 start_i[0] = 1'b0;
    @(negedge clk);
    chk("pre-abort busy", 64'(busy4), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy",   64'(busy4), 64'd0);
    chk("abort done",   64'(done4), 64'd0);
    chk("abort result", 64'(res4),  64'd0);
    chk("abort flag",   64'(flag4), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    begin
      int dn;
      dn = 0;
      repeat (8) begin @(negedge clk); if (done4) dn++; end
      chk("no done after abort", 64'(dn), 64'd0);
    end
    run_op("add 1+1", 2'b00, 8'd1, 8'd1, 1'b0, 1, 8'h02, 1'b0);

    // random traffic on both widths; the compare process checks every cycle
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      #2;
      rst = (($urandom % 100) == 0);
      for (int u = 0; u < 2; u++) begin
        start_i[u] = (($urandom % 3) != 0);
        op_i[u]    = 2'($urandom % 4);
        a_i[u]     = rnd_opnd(u == 0 ? 4 : 8);
        b_i[u]     = rnd_opnd(u == 0 ? 4 : 8);
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) start_i[u] = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_alu_seq.md
CAL_ALU_SEQ -- requirements
Module: cal_alu_seq

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new operation; sampled only when busy=0.
REQ-005 Port: op  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 Port: a  input  WIDTH  first operand, unsigned.
REQ-007 Port: b  input  WIDTH  second operand, unsigned.
REQ-008 Port: busy  output  1  high while an accepted operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result and flag are valid in this cycle.
REQ-010 Port: result  output  2*WIDTH  registered result; see REQ-016..REQ-019.
REQ-011 Port: flag  output  1  add carry, sub borrow, div-by-zero; 0 for mul.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 SHALL latch a, b and op and assert busy from the next cycle.
REQ-014 Add and sub SHALL go IDLE->DONE, asserting done 1 cycle after start is accepted.
REQ-015 Mul and div SHALL go IDLE->CALC, run exactly WIDTH iterations (one per cycle), then go to DONE; done SHALL assert WIDTH+1 cycles after start is accepted.
REQ-016 Add SHALL set result[WIDTH:0] = a+b, upper bits 0, and flag = result[WIDTH].
REQ-017 Sub SHALL set result[WIDTH-1:0] = (a-b) mod 2^WIDTH, upper bits 0, and flag = (a<b).
REQ-018 Mul SHALL produce the full 2*WIDTH-bit product by iterative shift-add, with flag=0.
REQ-019 Div SHALL use iterative restoring division and set result = {remainder, quotient}, each WIDTH bits, with flag=0.
REQ-020 Div with b=0 SHALL skip CALC (go IDLE->DONE, done after 1 cycle) and set quotient to all ones, remainder = a, flag=1.
REQ-021 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-022 start SHALL be ignored while busy=1; operand/op changes during CALC SHALL NOT affect the result.
REQ-023 DONE SHALL last exactly one cycle and return to IDLE; the earliest next start is accepted the cycle after done.
REQ-024 result and flag SHALL hold their last values until the next operation's done; intermediate values SHALL NOT appear on result.
REQ-025 Operands 0 and 2^WIDTH-1 SHALL give correct results with no overflow in result.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and drive busy=0, done=0, result=0 and flag=0.
REQ-027 Reset during CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst deasserts, start SHALL be accepted on the first rising clk edge.

Structure
REQ-029 Package cal_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the state encoding typedef.
REQ-030 One sub-module, cal_iter_step, SHALL hold the combinational single-iteration logic for shift-add and restoring-subtract; cal_alu_seq holds the FSM, counter and registers.
REQ-031 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide.

Verification (WIDTH=4)
REQ-032 Add: a=9, b=8, start -> done 1 cycle later, result=0x11, flag=1.
REQ-033 Sub: a=3, b=5 -> done 1 cycle later, result=0x0E, flag=1.
REQ-034 Mul: a=15, b=15 -> busy high for 5 cycles, done 5 cycles after start, result=0xE1, flag=0; a start pulse mid-CALC is ignored.
REQ-035 Div: a=13, b=4 -> done 5 cycles later, result=0x13, flag=0; then a=7, b=0 -> done 1 cycle later, result=0x7F, flag=1.
REQ-036 Reset abort: rst pulsed on the 2nd CALC cycle of mul -> busy, done, result and flag all 0 immediately, no done; the next add 1+1 gives result=0x02.
REQ-037 Regression: random ops and operands for WIDTH=4 and WIDTH=8 checked against a reference model, including 0 and all-ones operands.
